// File: rtl/aftab_rf_pkg.sv
// aftab_rf_pkg: shared constants and address-width helper for the AFTAB register file
package aftab_rf_pkg;
    localparam int AFTAB_REG_ZERO = 0;
    localparam int AFTAB_RF_DEFAULT_COUNT = 32;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/aftab_regfile_sb_if.sv
// aftab_regfile_sb_if: read, port-A write, reservation and port-B writeback bundle
interface aftab_regfile_sb_if import aftab_rf_pkg::*; #(
    parameter int size = 32,
    parameter int regCount = AFTAB_RF_DEFAULT_COUNT
);
    localparam int aw = clog2(regCount);
    logic [aw-1:0] rs1, rs2, rd, reserveRd, wbRd;
    logic [size-1:0] p1, p2, writeData, wbData;
    logic busy1, busy2, writeRegFile, setZero, setOne, reserve, reserveReady, wbValid, wafConflict;
    logic [aw:0] pendingCount;
    modport master(
        output rs1, rs2, rd, writeData, writeRegFile, setZero, setOne, reserve, reserveRd, wbValid, wbRd, wbData,
        input p1, p2, busy1, busy2, reserveReady, wafConflict, pendingCount
    );
    modport slave(
        input rs1, rs2, rd, writeData, writeRegFile, setZero, setOne, reserve, reserveRd, wbValid, wbRd, wbData,
        output p1, p2, busy1, busy2, reserveReady, wafConflict, pendingCount
    );
endinterface

// File: rtl/aftab_scoreboard.sv
// aftab_scoreboard: per-register busy bits for long-latency writes, hazard lookups and pending count
module aftab_scoreboard import aftab_rf_pkg::*; #(
    parameter int regCount = AFTAB_RF_DEFAULT_COUNT,
    parameter bit bypass = 1'b1,
    localparam int aw = clog2(regCount)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [aw-1:0] rs1_i,
    input  logic [aw-1:0] rs2_i,
    input  logic [aw-1:0] rd_i,
    input  logic          wr_en_i,
    input  logic          reserve_i,
    input  logic [aw-1:0] reserve_rd_i,
    input  logic          wb_valid_i,
    input  logic [aw-1:0] wb_rd_i,
    output logic          busy1_o,
    output logic          busy2_o,
    output logic          reserve_ready_o,
    output logic          waf_conflict_o,
    output logic [aw:0]   pending_o
);
    localparam logic [aw-1:0] Z = aw'(AFTAB_REG_ZERO);
    logic [regCount-1:0] busy_q, busy_d;
    logic [aw:0] pend_q, pend_d;
    assign reserve_ready_o = reserve_i && (reserve_rd_i == Z || !busy_q[reserve_rd_i] || (wb_valid_i && wb_rd_i == reserve_rd_i));
    assign waf_conflict_o = wr_en_i && rd_i != Z && (busy_q[rd_i] || (wb_valid_i && wb_rd_i == rd_i));
    assign busy1_o = busy_q[rs1_i] && !(bypass && wb_valid_i && wb_rd_i == rs1_i);
    assign busy2_o = busy_q[rs2_i] && !(bypass && wb_valid_i && wb_rd_i == rs2_i);
    assign pending_o = pend_q;
    // a reservation set after the writeback clear so a re-reserve on the same edge persists
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
        if (reserve_ready_o && reserve_rd_i != Z) busy_d[reserve_rd_i] = 1'b1;
        pend_d = '0;
        for (int i = 0; i < regCount; i++) pend_d = pend_d + (aw+1)'(busy_d[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/aftab_regfile_sb.sv
// aftab_regfile_sb: parametrised register file with optional bypass, second writeback port and busy scoreboard
module aftab_regfile_sb import aftab_rf_pkg::*; #(
    parameter int size = 32,
    parameter int regCount = AFTAB_RF_DEFAULT_COUNT,
    parameter bit bypass = 1'b1
) (
    input logic clk,
    input logic rst,
    aftab_regfile_sb_if.slave bus
);
    localparam int aw = clog2(regCount);
    localparam logic [aw-1:0] Z = aw'(AFTAB_REG_ZERO);
    logic [regCount-1:0][size-1:0] rf_q;
    logic any_a, waf, wr_a, wb_w;
    logic [size-1:0] a_val;
    assign any_a = bus.setZero | bus.setOne | bus.writeRegFile;
    assign a_val = bus.setZero ? '0 : bus.setOne ? size'(1) : bus.writeData;
    assign wr_a = any_a && bus.rd != Z && !waf;
    assign wb_w = bus.wbValid && bus.wbRd != Z;
    assign bus.wafConflict = waf;
    aftab_scoreboard #(.regCount(regCount), .bypass(bypass)) u_sb (
        .clk(clk),
        .rst(rst),
        .rs1_i(bus.rs1),
        .rs2_i(bus.rs2),
        .rd_i(bus.rd),
        .wr_en_i(any_a),
        .reserve_i(bus.reserve),
        .reserve_rd_i(bus.reserveRd),
        .wb_valid_i(bus.wbValid),
        .wb_rd_i(bus.wbRd),
        .busy1_o(bus.busy1),
        .busy2_o(bus.busy2),
        .reserve_ready_o(bus.reserveReady),
        .waf_conflict_o(waf),
        .pending_o(bus.pendingCount)
    );
    // port A is blocked whenever port B targets the same register, so the two writes never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rf_q <= '0;
        else begin
            if (wb_w) rf_q[bus.wbRd] <= bus.wbData;
            if (wr_a) rf_q[bus.rd] <= a_val;
        end
    end
    assign bus.p1 = bus.rs1 == Z ? '0 : (bypass && wb_w && bus.wbRd == bus.rs1) ? bus.wbData :
                    (bypass && wr_a && bus.rd == bus.rs1) ? a_val : rf_q[bus.rs1];
    assign bus.p2 = bus.rs2 == Z ? '0 : (bypass && wb_w && bus.wbRd == bus.rs2) ? bus.wbData :
                    (bypass && wr_a && bus.rd == bus.rs2) ? a_val : rf_q[bus.rs2];
endmodule

// File: tb/tb_aftab_regfile_sb.sv
// tb_aftab_regfile_sb: directed scoreboard bench driving a bypass and a non-bypass register file in lockstep
module tb_aftab_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    string tq[$];
    logic [31:0] vq[$];
    aftab_regfile_sb_if #(.size(32), .regCount(32)) b1 ();
    aftab_regfile_sb_if #(.size(32), .regCount(32)) b0 ();
    aftab_regfile_sb #(.size(32), .regCount(32), .bypass(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    aftab_regfile_sb #(.size(32), .regCount(32), .bypass(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    assign b0.rs1 = b1.rs1;
    assign b0.rs2 = b1.rs2;
    assign b0.rd = b1.rd;
    assign b0.writeData = b1.writeData;
    assign b0.writeRegFile = b1.writeRegFile;
    assign b0.setZero = b1.setZero;
    assign b0.setOne = b1.setOne;
    assign b0.reserve = b1.reserve;
    assign b0.reserveRd = b1.reserveRd;
    assign b0.wbValid = b1.wbValid;
    assign b0.wbRd = b1.wbRd;
    assign b0.wbData = b1.wbData;
    always #5 clk = ~clk;
    task automatic push(input string t, input logic [31:0] v);
        tq.push_back(t);
        vq.push_back(v);
    endtask
    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] v;
        checks++;
        if (tq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            t = tq.pop_front();
            v = vq.pop_front();
            assert (obs === v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, v);
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        b1.rs1 = '0; b1.rs2 = '0; b1.rd = '0; b1.writeData = '0;
        b1.writeRegFile = 1'b0; b1.setZero = 1'b0; b1.setOne = 1'b0;
        b1.reserve = 1'b0; b1.reserveRd = '0; b1.wbValid = 1'b0; b1.wbRd = '0; b1.wbData = '0;
    endtask
    initial begin
        idle();
        b1.rs1 = 5'd5;
        push("rst_p1", 32'h0); push("rst_pending", 32'h0); push("rst_waf", 32'h0);
        #1;
        chk(b1.p1); chk(32'(b1.pendingCount)); chk(32'(b1.wafConflict));
        tick();
        rst = 1'b0;
        b1.rd = 5'd5; b1.writeData = 32'hDEADBEEF; b1.writeRegFile = 1'b1; b1.reserve = 1'b1; b1.reserveRd = 5'd8;
        push("res8_ready", 32'h1);
        #1;
        chk(32'(b1.reserveReady));
        tick();
        idle(); b1.rs1 = 5'd5; b1.rs2 = 5'd8;
        push("x5_stored", 32'hDEADBEEF); push("x8_busy", 32'h1); push("pending_one", 32'h1);
        #1;
        chk(b0.p1); chk(32'(b1.busy2)); chk(32'(b1.pendingCount));
        rst = 1'b1;
        push("midrst_p1", 32'h0); push("midrst_pending", 32'h0); push("midrst_busy2", 32'h0);
        #1;
        chk(b1.p1); chk(32'(b1.pendingCount)); chk(32'(b1.busy2));
        tick();
        rst = 1'b0;
        b1.rd = 5'd7; b1.writeData = 32'h55; b1.writeRegFile = 1'b1;
        tick();
        b1.setZero = 1'b1; b1.setOne = 1'b1; b1.rs1 = 5'd7;
        push("prio0_bypass", 32'h0); push("prio0_old", 32'h55);
        #1;
        chk(b1.p1); chk(b0.p1);
        tick();
        push("prio0_stored", 32'h0);
        chk(b0.p1);
        b1.setZero = 1'b0;
        push("prio1_bypass", 32'h1); push("prio1_old", 32'h0);
        #1;
        chk(b1.p1); chk(b0.p1);
        tick();
        push("prio1_stored", 32'h1);
        chk(b0.p1);
        idle(); b1.rd = 5'd3; b1.writeData = 32'h1234; b1.writeRegFile = 1'b1; b1.rs1 = 5'd3;
        push("byp_same", 32'h1234); push("nobyp_same", 32'h0);
        #1;
        chk(b1.p1); chk(b0.p1);
        tick();
        idle(); b1.rs1 = 5'd3;
        push("nobyp_next", 32'h1234);
        #1;
        chk(b0.p1);
        b1.reserve = 1'b1; b1.reserveRd = 5'd9; b1.rs2 = 5'd9;
        push("res9_ready", 32'h1); push("res9_busy_pre", 32'h0);
        #1;
        chk(32'(b1.reserveReady)); chk(32'(b1.busy2));
        tick();
        b1.reserve = 1'b0;
        push("raw_pending", 32'h1); push("raw_busy2", 32'h1);
        #1;
        chk(32'(b1.pendingCount)); chk(32'(b1.busy2));
        b1.wbValid = 1'b1; b1.wbRd = 5'd9; b1.wbData = 32'hA5;
        push("wb_busy2_byp", 32'h0); push("wb_busy2_nobyp", 32'h1); push("wb_p2_byp", 32'hA5); push("wb_p2_nobyp", 32'h0);
        #1;
        chk(32'(b1.busy2)); chk(32'(b0.busy2)); chk(b1.p2); chk(b0.p2);
        tick();
        idle(); b1.rs2 = 5'd9;
        push("after_wb_busy2", 32'h0); push("after_wb_p2", 32'hA5); push("after_wb_pending", 32'h0);
        #1;
        chk(32'(b0.busy2)); chk(b0.p2); chk(32'(b1.pendingCount));
        b1.reserve = 1'b1; b1.reserveRd = 5'd4;
        tick();
        idle(); b1.rd = 5'd4; b1.writeData = 32'h11; b1.writeRegFile = 1'b1; b1.rs1 = 5'd4;
        push("waf_busy", 32'h1); push("waf_busy_p1", 32'h0);
        #1;
        chk(32'(b1.wafConflict)); chk(b1.p1);
        tick();
        push("x4_unchanged", 32'h0);
        chk(b0.p1);
        b1.wbValid = 1'b1; b1.wbRd = 5'd4; b1.wbData = 32'h22;
        push("waf_collide", 32'h1); push("collide_byp", 32'h22);
        #1;
        chk(32'(b1.wafConflict)); chk(b1.p1);
        tick();
        idle(); b1.rs1 = 5'd4;
        push("x4_portb", 32'h22); push("x4_pending", 32'h0);
        #1;
        chk(b0.p1); chk(32'(b1.pendingCount));
        b1.reserve = 1'b1; b1.reserveRd = 5'd6;
        tick();
        b1.wbValid = 1'b1; b1.wbRd = 5'd6; b1.wbData = 32'h66;
        push("rereserve_ready", 32'h1);
        #1;
        chk(32'(b1.reserveReady));
        tick();
        idle(); b1.rs2 = 5'd6;
        push("rereserve_busy", 32'h1); push("rereserve_pending", 32'h1); push("rereserve_data", 32'h66);
        #1;
        chk(32'(b0.busy2)); chk(32'(b1.pendingCount)); chk(b0.p2);
        b1.reserve = 1'b1; b1.reserveRd = 5'd6;
        push("res_busy_ready", 32'h0);
        #1;
        chk(32'(b1.reserveReady));
        tick();
        b1.reserveRd = 5'd0;
        push("res0_ready", 32'h1);
        #1;
        chk(32'(b1.reserveReady));
        tick();
        idle(); b1.rd = 5'd0; b1.writeData = 32'hFF; b1.writeRegFile = 1'b1;
        push("res0_pending", 32'h1); push("x0_busy", 32'h0); push("x0_waf", 32'h0); push("x0_read", 32'h0);
        #1;
        chk(32'(b1.pendingCount)); chk(32'(b1.busy1)); chk(32'(b1.wafConflict)); chk(b1.p1);
        tick();
        idle(); b1.wbValid = 1'b1; b1.wbRd = 5'd6; b1.wbData = 32'h77;
        tick();
        idle();
        push("x0_stored", 32'h0); push("final_pending", 32'h0);
        #1;
        chk(b0.p1); chk(32'(b1.pendingCount));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aftab_regfile_sb.md
Name: aftab_regfile_sb

Overview:
- Parametrised successor of the AFTAB datapath register file.
- Generalised in data width and register count.
- Adds an optional same-cycle write-to-read bypass, a second writeback port for long-latency units (multiplier/divider, CSR), and a per-register busy scoreboard.
- The controller uses the scoreboard to detect RAW/WAW hazards and stall.

Parameters:
- size, 32, data width in bits.
- regCount, 32, number of architectural registers (power of 2, >=2); aw = log2(regCount).
- bypass, 1, 1 = read ports forward same-cycle write data; 0 = read returns stored value only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1  in  aw  read address, port 1.
- rs2  in  aw  read address, port 2.
- p1  out  size  read data, port 1.
- p2  out  size  read data, port 2.
- busy1  out  1  register rs1 has a pending long-latency write.
- busy2  out  1  register rs2 has a pending long-latency write.
- rd  in  aw  port-A (single-cycle) write address.
- writeData  in  size  port-A write data.
- writeRegFile  in  1  port-A write enable.
- setZero  in  1  port-A: write 0 to rd.
- setOne  in  1  port-A: write 1 to rd.
- reserve  in  1  request to mark reserveRd busy (long op issued).
- reserveRd  in  aw  register to reserve.
- reserveReady  out  1  reservation accepted this cycle.
- wbValid  in  1  port-B writeback valid.
- wbRd  in  aw  port-B write address.
- wbData  in  size  port-B write data.
- wafConflict  out  1  port-A write blocked this cycle (target busy or colliding with port B).
- pendingCount  out  aw+1  number of busy registers.

Behaviour:
- Reset (async, rst=1): all registers 0, all busy bits 0. Outputs: pendingCount=0, reserveReady=0 unless reserve asserted with a legal target, wafConflict=0. p1/p2 read 0.
- Register 0: hardwired zero. Writes to it are ignored. Its busy bit is never set. Reserving 0 gives reserveReady=1 and no state change.
- Port A priority per edge: setZero > setOne > writeRegFile. The value written is 0, 1 or writeData; only rd is affected.
- Port A is blocked (no write, wafConflict=1, combinational same cycle) when any port-A enable is active, rd!=0, and either:
  - busy[rd]=1 and not (wbValid && wbRd==rd); or
  - wbValid && wbRd==rd.
- Port B: on wbValid, at the edge, reg[wbRd]<=wbData and busy[wbRd]<=0. A port-B write to a non-busy register is legal (CSR path).
- Reservation:
  - reserveReady = reserve && (reserveRd==0 || !busy[reserveRd] || (wbValid && wbRd==reserveRd)).
  - On accept, busy[reserveRd]<=1 at the edge. Set has priority over a same-cycle wb clear, so the re-reservation persists.
  - reserve with a busy target: reserveReady=0, no state change. The controller holds reserve until accepted.
- pendingCount: registered. Equals the popcount of busy bits after each edge. Net change per edge is +1, -1 or 0, saturating impossible by construction (max regCount-1).
- Read (combinational, zero latency):
  - Address 0 returns 0.
  - When bypass=1, a read address matching an effective write this cycle returns the new value. Port B has priority over port A; port A bypasses only if not blocked.
  - Otherwise the stored value is returned.
  - busyN = busy[rsN] && !(wbValid && wbRd==rsN). A same-cycle writeback clears the hazard only when bypass=1; when bypass=0, busyN = busy[rsN].
- Reset mid-operation: all busy bits are cleared immediately. Any in-flight writeback arriving after reset deasserts is written normally.

Decomposition:
- Package aftab_rf_pkg holds:
  - constants AFTAB_REG_ZERO and AFTAB_RF_DEFAULT_COUNT;
  - a clog2 function for aw.
- Sub-module aftab_scoreboard (busy vector, reserve/clear logic, pendingCount, busy lookups) instantiated once.
- The data array and bypass muxes stay in the top level.

Test Plan:
- Reset: write 0xDEADBEEF to x5 via port A, assert rst mid-cycle -> p1(rs1=5)=0 immediately, pendingCount=0.
- Port-A priority: setZero=1, setOne=1, writeRegFile=1, rd=7, writeData=0x55 -> x7=0. Repeat with setZero=0 -> x7=1.
- Bypass: bypass=1, rd=3, writeData=0x1234, rs1=3 in the same cycle -> p1=0x1234 that cycle. With bypass=0 -> p1=old value, then 0x1234 next cycle.
- Scoreboard RAW: reserve x9 (reserveReady=1, pendingCount=1), rs2=9 -> busy2=1. wbValid, wbRd=9, wbData=0xA5 -> next cycle busy2=0, p2=0xA5, pendingCount=0.
- Conflicts:
  - x4 busy, port-A write to x4 -> wafConflict=1, x4 unchanged.
  - Same cycle wbValid/wbRd=4 plus port-A write x4=0x11, wbData=0x22 -> x4=0x22, wafConflict=1.
- Re-reserve on writeback: x6 busy, same cycle wbRd=6 and reserve x6 -> reserveReady=1, busy[6]=1 after the edge, pendingCount unchanged. Reserving x0 -> reserveReady=1, pendingCount unchanged.
